gpr_file_scoreboard: RTL and testbench
======================================

Name: gpr_file_scoreboard

Overview:
Parametrised general-purpose register file for the RISC-V core. It has a configurable data width, register count and number of combinational read ports, and register x0 is hardwired to zero. It adds optional write-to-read bypass and a per-register busy scoreboard (allocate/retire/flush) with a pending-count output. It sits between decode (read + allocate) and writeback (write/retire) and replaces the fixed 2-read, 32x32 register block.

Parameters:
XLEN, 32, register data width in bits
NUM_REGS, 32, number of registers; power of two, >= 2; index 0 is hardwired zero
NUM_RD, 2, number of independent read ports, >= 1
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding
AW (localparam), $clog2(NUM_REGS), register address width
CW (localparam), $clog2(NUM_REGS+1), pending-count width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable / retire strobe
wr_addr  in  AW  write register index
wr_data  in  XLEN  write data
rd_addr  in  NUM_RD*AW  packed read indices; port i = bits [i*AW +: AW]
rd_data  out  NUM_RD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN]
rd_busy  out  NUM_RD  port i's register has a pending producer
alloc_en  in  1  mark alloc_addr busy (new in-flight producer)
alloc_addr  in  AW  register to allocate
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NUM_REGS  registered scoreboard; bit 0 always 0
pending_cnt  out  CW  registered count of set bits in busy_vec

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): all registers 0, busy_vec 0, pending_cnt 0. The outputs follow combinationally from the cleared state.
- Read (combinational, 0 latency), per port i:
  - If rd_addr[i]==0: rd_data[i]=0 and rd_busy[i]=0.
  - Else if BYPASS=1 and we=1 and wr_addr==rd_addr[i]: rd_data[i]=wr_data and rd_busy[i]=0, regardless of a same-cycle alloc of that address.
  - Otherwise: rd_data[i]=stored value and rd_busy[i]=busy_vec[rd_addr[i]].
  - With BYPASS=0, a same-cycle write is visible on reads from the next cycle.
- Write: when we=1 and wr_addr!=0, regs[wr_addr] takes wr_data at the clock edge. Writes to index 0 are discarded. The write is performed even when flush=1.
- Scoreboard next state for each register r!=0, in priority order:
  1. flush=1: busy[r] becomes 0; alloc_en is ignored.
  2. alloc_en=1 and alloc_addr==r: busy[r] becomes 1. This overrides a same-cycle retire of r, because the newer producer wins.
  3. we=1 and wr_addr==r: busy[r] becomes 0.
  4. Otherwise busy[r] holds.
- Allocating or retiring index 0 has no effect; busy[0] is constant 0.
- Re-allocating an already busy register leaves it busy, and the count does not change.
- A retire of a non-busy register is legal: the data is written and busy stays 0.
- pending_cnt is a register updated on the same edge as busy_vec. It always equals popcount(busy_vec), with range 0..NUM_REGS-1, and never wraps.
- All read ports are independent; identical addresses on several ports return identical results.

Test Plan:
1. Reset then read: pulse rst_n low mid-run after writing x5=0xDEAD_BEEF -> with no clock edge, all rd_data=0, busy_vec=0, pending_cnt=0.
2. Write/read and x0: write x3=0x1234_5678, then write x0=0xFFFF_FFFF; read ports 0/1 = x3/x0 -> 0x1234_5678 / 0x0000_0000.
3. Bypass: BYPASS=1, we=1, wr_addr=7, wr_data=0xA5A5_A5A5, rd_addr[1]=7 in the same cycle -> rd_data[1]=0xA5A5_A5A5 that cycle. With BYPASS=0, the same stimulus gives the old value that cycle and 0xA5A5_A5A5 the next.
4. Scoreboard: alloc x4, x9, x0 on consecutive cycles -> busy_vec bits 4 and 9 set, pending_cnt=2. Then retire x4 with data 0x11 -> bit 4 clears, pending_cnt=1, and a read of x4 gives 0x11 with rd_busy=0.
5. Simultaneous events: x9 busy; alloc_en=1 on x9 with we=1, wr_addr=9 in the same cycle -> x9 written, busy[9] stays 1, pending_cnt unchanged.
6. Flush: x2, x6, x31 busy, then flush=1 with alloc_en=1 on x12 and we=1 on x6=0x77 -> busy_vec=0, pending_cnt=0, regs[6]=0x77, x12 not busy.

Source files
------------

// File: rtl/gpr_file_scoreboard.sv
// gpr_file_scoreboard: parametrised register file with x0 hardwired to zero,
// optional write-to-read bypass and a per-register busy scoreboard with a
// registered pending-producer count.
//
// Interface timing: reads are purely combinational (0 latency). Writes,
// allocations and flushes take effect at the rising clock edge. There is no
// valid/ready handshake: we, alloc_en and flush are single-cycle strobes that
// the block always accepts.
module gpr_file_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = $clog2(NUM_REGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic [CW-1:0]          pending_cnt
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CW-1:0]       w_cnt_nxt;

  // Register storage: writes to x0 are dropped; flush does not block writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else if (we && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: flush beats alloc, alloc beats retire, x0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (we) begin
        w_busy_nxt[wr_addr] = 1'b0;
      end
      if (alloc_en) begin
        w_busy_nxt[alloc_addr] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Population count of the next scoreboard so the count register tracks it exactly.
  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_cnt_nxt = w_cnt_nxt + {{(CW-1){1'b0}}, w_busy_nxt[r]};
    end
  end

  // Scoreboard and pending count update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy_vec    = r_busy;
  assign pending_cnt = r_cnt;

  // Independent read ports; a bypassed write also hides the busy bit it retires.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    assign w_addr = rd_addr[g*AW +: AW];
    assign w_hit  = (BYPASS != 0) && we && (wr_addr == w_addr);
    assign rd_data[g*XLEN +: XLEN] = (w_addr == '0) ? '0 :
                                     w_hit          ? wr_data :
                                                      r_regs[w_addr];
    assign rd_busy[g] = (w_addr != '0) && !w_hit && r_busy[w_addr];
  end

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// tb_gpr_file_scoreboard: directed bench for gpr_file_scoreboard. Two copies
// share all inputs: u_dut with bypass enabled, u_dut_nb with bypass disabled.
// Expected values are queued when stimulus is driven and popped as the
// matching output is sampled.
module tb_gpr_file_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic             clk;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             flush;

  logic [NRD*XLEN-1:0] rd_data,  rd_data_nb;
  logic [NRD-1:0]      rd_busy,  rd_busy_nb;
  logic [NREG-1:0]     busy_vec, busy_vec_nb;
  logic [CW-1:0]       pending_cnt, pending_cnt_nb;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  gpr_file_scoreboard #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(busy_vec), .pending_cnt(pending_cnt)
  );

  gpr_file_scoreboard #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(busy_vec_nb), .pending_cnt(pending_cnt_nb)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    we = 1'b0; alloc_en = 1'b0; flush = 1'b0;
  endtask

  // Advance one rising edge, then settle 1 unit so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic drive_alloc(input logic [AW-1:0] a);
    alloc_en = 1'b1; alloc_addr = a;
  endtask

  task automatic set_rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    rd_addr = {p1, p0};
  endtask

  // ---------------- scoreboard ----------------
  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; alloc_addr = '0;
    set_rd(5'd0, 5'd0);
    #12;
    rst_n = 1'b1;
    #1;
    push(32'h0); check("reset_busy_vec", busy_vec);
    push(32'h0); check("reset_pending", {26'b0, pending_cnt});

    // Write x5 and allocate it in the same cycle: data lands, alloc wins over retire.
    drive_write(5'd5, 32'hDEAD_BEEF);
    drive_alloc(5'd5);
    step();
    idle();
    set_rd(5'd5, 5'd5);
    #1;
    push(32'hDEAD_BEEF); check("x5_written", rd_data[31:0]);
    push(32'h0000_0020); check("x5_busy_vec", busy_vec);
    push(32'd1);         check("x5_pending", {26'b0, pending_cnt});
    push(32'd1);         check("x5_rd_busy", {31'b0, rd_busy[0]});

    // Asynchronous reset with no clock edge in the window.
    rst_n = 1'b0;
    #2;
    push(32'h0); check("async_rst_rd0", rd_data[31:0]);
    push(32'h0); check("async_rst_busy", busy_vec);
    push(32'h0); check("async_rst_pending", {26'b0, pending_cnt});
    #1;
    rst_n = 1'b1;

    // x3 written, x0 write discarded.
    drive_write(5'd3, 32'h1234_5678);
    step();
    drive_write(5'd0, 32'hFFFF_FFFF);
    step();
    idle();
    set_rd(5'd3, 5'd0);
    #1;
    push(32'h1234_5678); check("read_x3", rd_data[31:0]);
    push(32'h0);         check("read_x0", rd_data[63:32]);
    push(32'h0);         check("read_x0_nb", rd_data_nb[63:32]);
    push(32'h0);         check("read_x0_busy", {30'b0, rd_busy});

    // Bypass: same-cycle write to x7 seen on port 1 only when BYPASS=1.
    set_rd(5'd3, 5'd7);
    drive_write(5'd7, 32'hA5A5_A5A5);
    #1;
    push(32'hA5A5_A5A5); check("bypass_x7", rd_data[63:32]);
    push(32'h0);         check("nobypass_x7_old", rd_data_nb[63:32]);
    push(32'h1234_5678); check("bypass_other_port", rd_data[31:0]);
    step();
    idle();
    #1;
    push(32'hA5A5_A5A5); check("nobypass_x7_next", rd_data_nb[63:32]);

    // Scoreboard: alloc x4, x9, x0.
    drive_alloc(5'd4); step();
    drive_alloc(5'd9); step();
    drive_alloc(5'd0); step();
    idle();
    set_rd(5'd4, 5'd9);
    #1;
    push(32'h0000_0210); check("alloc_busy_vec", busy_vec);
    push(32'd2);         check("alloc_pending", {26'b0, pending_cnt});
    push(32'd3);         check("alloc_rd_busy", {30'b0, rd_busy});

    // Retire x4 with 0x11; same-cycle read bypasses and hides busy only with BYPASS=1.
    drive_write(5'd4, 32'h11);
    #1;
    push(32'h11); check("retire_bypass_data", rd_data[31:0]);
    push(32'h0);  check("retire_bypass_busy", {31'b0, rd_busy[0]});
    push(32'h1);  check("retire_nb_busy", {31'b0, rd_busy_nb[0]});
    step();
    idle();
    #1;
    push(32'h0000_0200); check("retire_busy_vec", busy_vec);
    push(32'd1);         check("retire_pending", {26'b0, pending_cnt});
    push(32'h11);        check("retire_read_x4", rd_data_nb[31:0]);
    push(32'h0);         check("retire_rd_busy_x4", {31'b0, rd_busy[0]});

    // Alloc and retire x9 together: written, stays busy, count unchanged.
    drive_alloc(5'd9);
    drive_write(5'd9, 32'h99);
    step();
    idle();
    set_rd(5'd9, 5'd9);
    #1;
    push(32'h0000_0200); check("simul_busy_vec", busy_vec);
    push(32'd1);         check("simul_pending", {26'b0, pending_cnt});
    push(32'h99);        check("simul_data_x9", rd_data[63:32]);
    push(32'd3);         check("simul_rd_busy", {30'b0, rd_busy});

    // Build x2, x6, x31 busy; re-allocating x2 must not change the count.
    drive_alloc(5'd2);  step();
    drive_alloc(5'd6);  step();
    drive_alloc(5'd31); step();
    drive_alloc(5'd2);  step();
    idle();
    #1;
    push(32'h8000_0244); check("preflush_busy_vec", busy_vec);
    push(32'd4);         check("preflush_pending", {26'b0, pending_cnt});

    // Flush with alloc x12 and write x6=0x77 in the same cycle.
    flush = 1'b1;
    drive_alloc(5'd12);
    drive_write(5'd6, 32'h77);
    step();
    idle();
    set_rd(5'd6, 5'd12);
    #1;
    push(32'h0);  check("flush_busy_vec", busy_vec);
    push(32'h0);  check("flush_pending", {26'b0, pending_cnt});
    push(32'h77); check("flush_write_x6", rd_data[31:0]);
    push(32'h0);  check("flush_rd_busy", {30'b0, rd_busy});

    // Identical addresses on both ports return identical data.
    set_rd(5'd6, 5'd6);
    #1;
    push(32'h77); check("dup_port0", rd_data[31:0]);
    push(32'h77); check("dup_port1", rd_data[63:32]);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL leftover_expected: observed %0d queued, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
